vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Display-side consumer of image_ram for the obstacle game.
- Walks a 640x480@60 raster on the 25 MHz pixel clock and issues x_vga/y_vga read addresses to the image_ram VGA port, scaling the 160x120 framebuffer by 4 in each axis.
- Takes the 3-bit dout_vga colour and drives registered VGA pins: RGB, hsync, vsync and blank.
- Runs independently of the processor write side; its clk ties to image_ram clk_vga.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- SCALE_SHIFT, 2, log2 of pixel replication factor
- RAM_LATENCY, 1, cycles from x_vga/y_vga to valid dout_vga

Ports:
- clk  in  1  pixel clock, 25 MHz
- reset  in  1  asynchronous, active-low reset
- x_vga  out  8  framebuffer column address to image_ram
- y_vga  out  7  framebuffer row address to image_ram
- dout_vga  in  3  pixel colour from image_ram: bit2=R, bit1=G, bit0=B
- vga_r  out  8  red, replicated from dout_vga[2]
- vga_g  out  8  green, replicated from dout_vga[1]
- vga_b  out  8  blue, replicated from dout_vga[0]
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_blank_n  out  1  high during the visible area
- frame_start  out  1  one-cycle pulse coincident with pin pixel (0,0)

Behaviour:
- Reset: applies asynchronously while reset is low. Values held during reset:
  - hcount=0, vcount=0
  - x_vga=0, y_vga=0
  - vga_r/g/b=0
  - vga_hs=1, vga_vs=1
  - vga_blank_n=0, frame_start=0
- Deasserting reset mid-frame restarts the raster at (0,0). No partial line is emitted; the pipeline flushes to blanked values.
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = 525.
  - hcount increments every cycle and wraps from H_TOTAL-1 to 0.
  - vcount increments only on that wrap, and wraps from V_TOTAL-1 to 0 in the same cycle as hcount wraps.
- Stage 0 (counter cycle n):
  - active = (hcount<H_ACTIVE) && (vcount<V_ACTIVE)
  - hs_raw low for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751
  - vs_raw low for 490 <= vcount < 492
- Stage 1 (cycle n+1):
  - x_vga = hcount>>SCALE_SHIFT, truncated to 8 bits. y_vga = vcount>>SCALE_SHIFT, truncated to 7 bits.
  - Registered; x_vga and y_vga hold their last value outside the active area (don't-care, but never X).
- dout_vga is valid at cycle n+1+RAM_LATENCY.
- Output stage (cycle n+2+RAM_LATENCY, default n+3):
  - vga_r = {8{dout_vga[2]}}, and likewise for g and b, when the delayed active flag is 1; otherwise all RGB = 0.
  - vga_hs, vga_vs and vga_blank_n are the stage-0 values delayed by exactly 2+RAM_LATENCY cycles, so sync, blank and colour stay aligned per pixel.
- frame_start = 1 exactly when the delayed (hcount,vcount) equals (0,0). Once per 420000 cycles.
- No handshake: the read port is always enabled. Processor writes to a pixel appear on screen from the next scan of that pixel.
- Legal parameter constraints:
  - H_ACTIVE>>SCALE_SHIFT <= 256 and V_ACTIVE>>SCALE_SHIFT <= 128.
  - Counter widths are derived via $clog2(H_TOTAL) and $clog2(V_TOTAL).

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 timing constants, and derived H_TOTAL/V_TOTAL and sync start/end values
  - colour bit-index constants (R=2, G=1, B=0)
- Sub-module vga_delay_line (params WIDTH, DEPTH; async active-low reset to a parameterised RESET_VAL). It delays {hs, vs, active, frame0} by 2+RAM_LATENCY.

Test Plan:
- Reset release, count 800 cycles -> vga_hs low for exactly 96 consecutive cycles per line; first falling edge 656+3 cycles after reset release.
- Full frame -> vga_vs low for exactly 1600 cycles (2 lines); frame_start pulses once, 420000 cycles apart across two frames.
- Addressing: at counter (hcount=13, vcount=9) -> x_vga=3, y_vga=2 one cycle later; the same address is held for 4 consecutive cycles across hcount 12..15.
- Colour path: behavioural RAM model (1-cycle latency) with pixel (3,2)=3'b101 -> pins show r=8'hFF, g=8'h00, b=8'hFF for 4 pixels on lines 8..11, exactly 3 cycles after the counter position.
- Blanking: RAM returns 3'b111 everywhere -> RGB=0 whenever vga_blank_n=0; 640 visible pixels per line and 480 visible lines per frame.
- Reset mid-frame: assert reset at vcount=200 for 3 cycles -> all outputs at reset values immediately (asynchronous); after release the timing matches the first test from (0,0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_pkg : 640x480@60 timing constants and colour bit indices  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vga_timing_pkg;

    localparam int c_H_ACTIVE = 640;
    localparam int c_H_FP     = 16;
    localparam int c_H_SYNC   = 96;
    localparam int c_H_BP     = 48;
    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FP     = 10;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BP     = 33;

    localparam int c_H_TOTAL    = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;
    localparam int c_V_TOTAL    = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;
    localparam int c_HS_START   = c_H_ACTIVE + c_H_FP;
    localparam int c_HS_END     = c_HS_START + c_H_SYNC;
    localparam int c_VS_START   = c_V_ACTIVE + c_V_FP;
    localparam int c_VS_END     = c_VS_START + c_V_SYNC;

    localparam int c_SCALE_SHIFT = 2;
    localparam int c_RAM_LATENCY = 1;

    localparam int c_X_W      = 8;
    localparam int c_Y_W      = 7;
    localparam int c_COLOUR_W = 3;
    localparam int c_PIN_W    = 8;

    localparam int c_R_BIT = 2;
    localparam int c_G_BIT = 1;
    localparam int c_B_BIT = 0;

    // Bit positions of the per-pixel control bundle carried down the pipeline
    localparam int c_TAP_HS  = 3;
    localparam int c_TAP_VS  = 2;
    localparam int c_TAP_ACT = 1;
    localparam int c_TAP_F0  = 0;
    localparam int c_TAP_W   = 4;

    function automatic logic [c_PIN_W-1:0] colour_expand(input logic bit_in);
        return {c_PIN_W{bit_in}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_scanout_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_scanout_if : image_ram read port plus VGA pin bundle             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface vga_scanout_if;
    import vga_timing_pkg::*;

    logic [c_X_W-1:0]      x_vga;
    logic [c_Y_W-1:0]      y_vga;
    logic [c_COLOUR_W-1:0] dout_vga;
    logic [c_PIN_W-1:0]    vga_r;
    logic [c_PIN_W-1:0]    vga_g;
    logic [c_PIN_W-1:0]    vga_b;
    logic                  vga_hs;
    logic                  vga_vs;
    logic                  vga_blank_n;
    logic                  frame_start;

    modport master (
        output x_vga, y_vga, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start,
        input  dout_vga
    );

    modport slave (
        input  x_vga, y_vga, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start,
        output dout_vga
    );
endinterface
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_delay_line : fixed-depth shift register, async reset to a value  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vga_delay_line #(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= RESET_VAL;
            end
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_scanout : raster walker reading image_ram and driving VGA pins   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vga_scanout
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = c_H_ACTIVE,
    parameter int H_FP        = c_H_FP,
    parameter int H_SYNC      = c_H_SYNC,
    parameter int H_BP        = c_H_BP,
    parameter int V_ACTIVE    = c_V_ACTIVE,
    parameter int V_FP        = c_V_FP,
    parameter int V_SYNC      = c_V_SYNC,
    parameter int V_BP        = c_V_BP,
    parameter int SCALE_SHIFT = c_SCALE_SHIFT,
    parameter int RAM_LATENCY = c_RAM_LATENCY
) (
    input  wire logic     clk,
    input  wire logic     reset,
    vga_scanout_if.master bus
);
    localparam int c_HT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_VT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW   = $clog2(c_HT);
    localparam int c_VW   = $clog2(c_VT);
    localparam int c_PIPE = 2 + RAM_LATENCY;

    localparam logic [c_HW-1:0] c_H_LAST = c_HW'(c_HT - 1);
    localparam logic [c_HW-1:0] c_H_ACT  = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_HS_LO  = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_HS_HI  = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_VW-1:0] c_V_LAST = c_VW'(c_VT - 1);
    localparam logic [c_VW-1:0] c_V_ACT  = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_VS_LO  = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_VS_HI  = c_VW'(V_ACTIVE + V_FP + V_SYNC);

    // Idle bundle: syncs deasserted (high), blanked, no frame pulse
    localparam logic [c_TAP_W-1:0] c_TAP_IDLE = 4'b1100;

    logic [c_HW-1:0]    r_hcount;
    logic [c_VW-1:0]    r_vcount;
    logic [c_X_W-1:0]   r_x_vga;
    logic [c_Y_W-1:0]   r_y_vga;
    logic [c_PIN_W-1:0] r_vga_r;
    logic [c_PIN_W-1:0] r_vga_g;
    logic [c_PIN_W-1:0] r_vga_b;

    logic               w_active;
    logic               w_hs_raw;
    logic               w_vs_raw;
    logic               w_frame0;
    logic [c_TAP_W-1:0] w_tap_d;
    logic [c_TAP_W-1:0] w_tap_q;
    logic               w_colour_act;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (r_hcount == c_H_LAST) begin
            r_hcount <= '0;
            r_vcount <= (r_vcount == c_V_LAST) ? '0 : r_vcount + 1'b1;
        end else begin
            r_hcount <= r_hcount + 1'b1;
        end
    end

    assign w_active = (r_hcount < c_H_ACT) && (r_vcount < c_V_ACT);
    assign w_hs_raw = !((r_hcount >= c_HS_LO) && (r_hcount < c_HS_HI));
    assign w_vs_raw = !((r_vcount >= c_VS_LO) && (r_vcount < c_VS_HI));
    assign w_frame0 = (r_hcount == '0) && (r_vcount == '0);
    assign w_tap_d  = {w_hs_raw, w_vs_raw, w_active, w_frame0};

    // Address only moves inside the visible area so the RAM port sees no glitches in blanking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x_vga <= '0;
            r_y_vga <= '0;
        end else if (w_active) begin
            r_x_vga <= c_X_W'(r_hcount >> SCALE_SHIFT);
            r_y_vga <= c_Y_W'(r_vcount >> SCALE_SHIFT);
        end
    end

    vga_delay_line #(
        .WIDTH     (c_TAP_W),
        .DEPTH     (c_PIPE),
        .RESET_VAL (c_TAP_IDLE)
    ) u_ctrl_dly (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_tap_d),
        .o_q   (w_tap_q)
    );

    // One stage shorter: gates the colour register that forms the last pipeline stage
    vga_delay_line #(
        .WIDTH     (1),
        .DEPTH     (c_PIPE - 1),
        .RESET_VAL (1'b0)
    ) u_colour_dly (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_active),
        .o_q   (w_colour_act)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vga_r <= '0;
            r_vga_g <= '0;
            r_vga_b <= '0;
        end else if (w_colour_act) begin
            r_vga_r <= colour_expand(bus.dout_vga[c_R_BIT]);
            r_vga_g <= colour_expand(bus.dout_vga[c_G_BIT]);
            r_vga_b <= colour_expand(bus.dout_vga[c_B_BIT]);
        end else begin
            r_vga_r <= '0;
            r_vga_g <= '0;
            r_vga_b <= '0;
        end
    end

    assign bus.x_vga       = r_x_vga;
    assign bus.y_vga       = r_y_vga;
    assign bus.vga_r       = r_vga_r;
    assign bus.vga_g       = r_vga_g;
    assign bus.vga_b       = r_vga_b;
    assign bus.vga_hs      = w_tap_q[c_TAP_HS];
    assign bus.vga_vs      = w_tap_q[c_TAP_VS];
    assign bus.vga_blank_n = w_tap_q[c_TAP_ACT];
    assign bus.frame_start = w_tap_q[c_TAP_F0];
endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_scanout : full-size and shrunk-timing scanout vs pixel model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_vga_scanout;

    typedef struct packed {
        int ha; int hfp; int hsync; int hbp;
        int va; int vfp; int vsync; int vbp;
    } tim_t;

    localparam tim_t c_TA = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam tim_t c_TB = '{64, 4, 8, 4, 48, 2, 2, 3};

    typedef struct {
        string       name;
        int          k;
        logic        chk_pins;
        logic [31:0] pins;
        logic        chk_addr;
        logic [7:0]  x;
        logic [6:0]  y;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic chk_en = 1'b0;
    int   k = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [2:0] mem [128][256];
    vec_t       vecs [$];

    always #20 clk = ~clk;

    vga_scanout_if bus_a ();
    vga_scanout_if bus_b ();

    vga_scanout u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    vga_scanout #(
        .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (48), .V_FP (2), .V_SYNC (2), .V_BP (3)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // image_ram read ports, one-cycle latency, shared contents
    always @(posedge clk) bus_a.dout_vga <= mem[bus_a.y_vga][bus_a.x_vga];
    always @(posedge clk) bus_b.dout_vga <= mem[bus_b.y_vga][bus_b.x_vga];

    // k = clock edges since reset release; counter position equals k
    always @(posedge clk or negedge reset) begin
        if (!reset) k <= 0;
        else        k <= k + 1;
    end

    logic [31:0] pins_a, pins_b, addr_a, addr_b;
    assign pins_a = {4'h0, bus_a.vga_r, bus_a.vga_g, bus_a.vga_b,
                     bus_a.vga_hs, bus_a.vga_vs, bus_a.vga_blank_n, bus_a.frame_start};
    assign pins_b = {4'h0, bus_b.vga_r, bus_b.vga_g, bus_b.vga_b,
                     bus_b.vga_hs, bus_b.vga_vs, bus_b.vga_blank_n, bus_b.frame_start};
    assign addr_a = {17'h0, bus_a.x_vga, bus_a.y_vga};
    assign addr_b = {17'h0, bus_b.x_vga, bus_b.y_vga};

    function automatic logic [31:0] mk(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                       input logic hs, input logic vs, input logic bn, input logic fs);
        return {4'h0, r, g, b, hs, vs, bn, fs};
    endfunction

    // Pin values after k edges: pixel k-3 of an endless raster, blank idle before that
    function automatic logic [31:0] ref_pins(input int kk, input tim_t t);
        int p, h, v, ht, vt;
        logic hs, vs, bn, fs;
        logic [2:0] c;
        p = kk - 3;
        if (p < 0) return mk(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        ht = t.ha + t.hfp + t.hsync + t.hbp;
        vt = t.va + t.vfp + t.vsync + t.vbp;
        h  = p % ht;
        v  = (p / ht) % vt;
        hs = !(h >= t.ha + t.hfp && h < t.ha + t.hfp + t.hsync);
        vs = !(v >= t.va + t.vfp && v < t.va + t.vfp + t.vsync);
        bn = (h < t.ha) && (v < t.va);
        fs = (h == 0) && (v == 0);
        c  = bn ? mem[v / 4][h / 4] : 3'b000;
        return mk({8{c[2]}}, {8{c[1]}}, {8{c[0]}}, hs, vs, bn, fs);
    endfunction

    // Address after k edges belongs to pixel k-1; only defined for visible pixels
    function automatic logic ref_addr(input int kk, input tim_t t, output logic [31:0] a);
        int q, h, v, ht, vt;
        a  = 32'h0;
        q  = kk - 1;
        if (q < 0) return 1'b0;
        ht = t.ha + t.hfp + t.hsync + t.hbp;
        vt = t.va + t.vfp + t.vsync + t.vbp;
        h  = q % ht;
        v  = (q / ht) % vt;
        if (!(h < t.ha && v < t.va)) return 1'b0;
        a = {17'h0, 8'(h / 4), 7'(v / 4)};
        return 1'b1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at k=%0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    task automatic add_vec(input string nm, input int kk, input logic cp, input logic [31:0] p,
                           input logic ca, input logic [7:0] x, input logic [6:0] y);
        vec_t v;
        v.name = nm; v.k = kk; v.chk_pins = cp; v.pins = p;
        v.chk_addr = ca; v.x = x; v.y = y;
        vecs.push_back(v);
    endtask

    logic [31:0] exp_a, exp_b;
    always @(negedge clk) begin
        if (chk_en) begin
            check("pins_a", pins_a, ref_pins(k, c_TA));
            check("pins_b", pins_b, ref_pins(k, c_TB));
            if (ref_addr(k, c_TA, exp_a)) check("addr_a", addr_a, exp_a);
            if (ref_addr(k, c_TB, exp_b)) check("addr_b", addr_b, exp_b);
        end
    end

    int   hs_low_a, vis_a, fs_a, hs_fall_a, vs_low_b, vis_px_b, vis_lines_b;
    logic prev_hs_a, prev_bn_b;
    int   fs_b_q [$];

    always @(negedge clk) begin
        if (!reset) begin
            hs_low_a <= 0; vis_a <= 0; fs_a <= 0; hs_fall_a <= -1;
            vs_low_b <= 0; vis_px_b <= 0; vis_lines_b <= 0;
            prev_hs_a <= 1'b1; prev_bn_b <= 1'b0;
            fs_b_q.delete();
        end else begin
            if (k >= 3 && k < 803) begin
                if (!bus_a.vga_hs)     hs_low_a <= hs_low_a + 1;
                if (bus_a.vga_blank_n) vis_a    <= vis_a + 1;
            end
            if (prev_hs_a && !bus_a.vga_hs && hs_fall_a < 0) hs_fall_a <= k;
            prev_hs_a <= bus_a.vga_hs;
            if (bus_a.frame_start) fs_a <= fs_a + 1;
            if (k >= 3 && k < 4403) begin
                if (!bus_b.vga_vs)     vs_low_b <= vs_low_b + 1;
                if (bus_b.vga_blank_n) vis_px_b <= vis_px_b + 1;
                if (bus_b.vga_blank_n && !prev_bn_b) vis_lines_b <= vis_lines_b + 1;
            end
            prev_bn_b <= bus_b.vga_blank_n;
            if (bus_b.frame_start) fs_b_q.push_back(k);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired at k=%0d", k);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rst_pins;
        rst_pins = mk(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        for (int yy = 0; yy < 128; yy++)
            for (int xx = 0; xx < 256; xx++)
                mem[yy][xx] = 3'($urandom_range(0, 7));
        mem[0][0]   = 3'b110;
        mem[0][159] = 3'b001;
        mem[2][2]   = 3'b010;
        mem[2][3]   = 3'b101;
        mem[2][4]   = 3'b010;

        add_vec("rst_hold",   0,    1, rst_pins, 0, 8'd0, 7'd0);
        add_vec("pix_0_0",    3,    1, mk(8'hFF, 8'hFF, 8'h00, 1, 1, 1, 1), 0, 8'd0, 7'd0);
        add_vec("pix_1_0",    4,    1, mk(8'hFF, 8'hFF, 8'h00, 1, 1, 1, 0), 0, 8'd0, 7'd0);
        add_vec("pix_639_0",  642,  1, mk(8'h00, 8'h00, 8'hFF, 1, 1, 1, 0), 0, 8'd0, 7'd0);
        add_vec("pix_640_0",  643,  1, mk(8'h00, 8'h00, 8'h00, 1, 1, 0, 0), 0, 8'd0, 7'd0);
        add_vec("hs_pre",     658,  1, mk(8'h00, 8'h00, 8'h00, 1, 1, 0, 0), 0, 8'd0, 7'd0);
        add_vec("hs_first",   659,  1, mk(8'h00, 8'h00, 8'h00, 0, 1, 0, 0), 0, 8'd0, 7'd0);
        add_vec("hs_last",    754,  1, mk(8'h00, 8'h00, 8'h00, 0, 1, 0, 0), 0, 8'd0, 7'd0);
        add_vec("hs_post",    755,  1, mk(8'h00, 8'h00, 8'h00, 1, 1, 0, 0), 0, 8'd0, 7'd0);
        add_vec("pix_0_1",    803,  1, mk(8'hFF, 8'hFF, 8'h00, 1, 1, 1, 0), 0, 8'd0, 7'd0);
        add_vec("pix_11_8",   6414, 1, mk(8'h00, 8'hFF, 8'h00, 1, 1, 1, 0), 0, 8'd0, 7'd0);
        add_vec("pix_12_8",   6415, 1, mk(8'hFF, 8'h00, 8'hFF, 1, 1, 1, 0), 0, 8'd0, 7'd0);
        add_vec("pix_15_8",   6418, 1, mk(8'hFF, 8'h00, 8'hFF, 1, 1, 1, 0), 0, 8'd0, 7'd0);
        add_vec("pix_16_8",   6419, 1, mk(8'h00, 8'hFF, 8'h00, 1, 1, 1, 0), 0, 8'd0, 7'd0);
        add_vec("addr_12_9",  7213, 0, 32'h0, 1, 8'd3, 7'd2);
        add_vec("addr_13_9",  7214, 0, 32'h0, 1, 8'd3, 7'd2);
        add_vec("addr_15_9",  7216, 0, 32'h0, 1, 8'd3, 7'd2);
        add_vec("addr_16_9",  7217, 0, 32'h0, 1, 8'd4, 7'd2);
        add_vec("pix_12_11",  8815, 1, mk(8'hFF, 8'h00, 8'hFF, 1, 1, 1, 0), 0, 8'd0, 7'd0);

        #5 reset = 1'b0;
        #1 chk_en = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_addr_a", addr_a, 32'h0);
        check("rst_addr_b", addr_b, 32'h0);
        #1 reset = 1'b1;

        foreach (vecs[i]) begin
            while (k < vecs[i].k) @(negedge clk);
            #1;
            if (vecs[i].chk_pins) check(vecs[i].name, pins_a, vecs[i].pins);
            if (vecs[i].chk_addr) check(vecs[i].name, addr_a, {17'h0, vecs[i].x, vecs[i].y});
        end

        while (k < 9000) @(negedge clk);
        #1;
        check("hs_low_width_a",  32'(hs_low_a),  32'd96);
        check("hs_first_fall_a", 32'(hs_fall_a), 32'd659);
        check("visible_px_a",    32'(vis_a),     32'd640);
        check("frame_start_a",   32'(fs_a),      32'd1);
        check("vs_low_width_b",  32'(vs_low_b),  32'd160);
        check("visible_px_b",    32'(vis_px_b),  32'd3072);
        check("visible_ln_b",    32'(vis_lines_b), 32'd48);
        check("frame_start_b_n", 32'(fs_b_q.size()), 32'd3);
        if (fs_b_q.size() >= 3) begin
            check("frame_start_b_0",  32'(fs_b_q[0]), 32'd3);
            check("frame_period_b_1", 32'(fs_b_q[1] - fs_b_q[0]), 32'd4400);
            check("frame_period_b_2", 32'(fs_b_q[2] - fs_b_q[1]), 32'd4400);
        end

        // Mid-frame reset: small raster sits on line 20, large one on line 13
        while (k < 10437) @(negedge clk);
        @(posedge clk);
        #5 reset = 1'b0;
        #1;
        check("async_rst_pins_a", pins_a, rst_pins);
        check("async_rst_pins_b", pins_b, rst_pins);
        check("async_rst_addr_a", addr_a, 32'h0);
        check("async_rst_addr_b", addr_b, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;

        while (k < 900) @(negedge clk);
        #1;
        check("re_hs_first_fall_a", 32'(hs_fall_a), 32'd659);
        check("re_hs_low_width_a",  32'(hs_low_a),  32'd96);
        check("re_visible_px_a",    32'(vis_a),     32'd640);
        check("re_frame_start_b",   32'(fs_b_q.size()), 32'd1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
